// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Optional build macro used by the fetch top: FETCH_PERF_CNT_EN.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OPC_J = 6'b000010;

  // True when instr is an unconditional j whose target equals pc.
  // Callers pass the target field already truncated to the ROM index
  // width (upper target bits zeroed) and the pc zero-extended to 26 bits.
  function automatic logic is_self_jump(input logic [31:0] instr,
                                        input logic [25:0] pc);
    return (instr[31:26] == OPC_J) && (instr[25:0] == pc);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register with a flush input. A flush has priority
// over a load so a redirect can squash the word that would otherwise be
// captured; without load, the held word drops once it is accepted.
module fetch_out_reg #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  // Holding register: flush clears valid, load captures, accept drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_tag   <= in_tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the instruction ROM, registers
// each fetched word for decode, handles redirects and self-loop halts.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module imem_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t      state_r;
  fetch_state_t      state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              halted_r;
  logic              advance_s;
  logic              self_jump_s;
  logic              load_s;
  logic              flush_s;
  logic [ADDR_W-1:0] jump_tgt_s;

  assign imem_addr  = pc_r;
  assign halted     = halted_r;
  assign advance_s  = !out_valid || out_ready;
  assign jump_tgt_s = imem_data[ADDR_W-1:0];
  assign self_jump_s = is_self_jump({imem_data[31:26], 26'(jump_tgt_s)},
                                    26'(pc_r));

  // State, PC and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= ADDR_W'(RESET_PC);
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      halted_r <= (state_next_s == HALT);
    end
  end

  // Next-state: redirect beats halt detection; HALT is left only by reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          state_next_s = FETCH;
        end else if (advance_s && self_jump_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = FETCH;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath controls: PC update and capture/flush of the output stage.
  always_comb begin
    pc_next_s = pc_r;
    load_s    = 1'b0;
    flush_s   = 1'b0;
    case (state_r)
      FETCH: begin
        if (redirect_valid) begin
          pc_next_s = redirect_pc;
          flush_s   = 1'b1;
        end else if (advance_s) begin
          load_s = 1'b1;
          if (self_jump_s) begin
            pc_next_s = pc_r;
          end else begin
            pc_next_s = pc_r + ADDR_W'(1);
          end
        end else begin
          pc_next_s = pc_r;
        end
      end
      IDLE, HALT: begin
        pc_next_s = pc_r;
      end
      default: begin
        pc_next_s = pc_r;
      end
    endcase
  end

  fetch_out_reg #(
    .DATA_W (32),
    .TAG_W  (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .flush     (flush_s),
    .in_data   (imem_data),
    .in_tag    (pc_r),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_instr),
    .out_tag   (out_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  // Saturating handshake and stall counters, frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (state_r != HALT) begin
      if (out_valid && out_ready && (fetch_cnt != 32'hFFFF_FFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end else begin
        fetch_cnt <= fetch_cnt;
      end
      if ((state_r == FETCH) && out_valid && !out_ready &&
          (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end else begin
      fetch_cnt <= fetch_cnt;
      stall_cnt <= stall_cnt;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
